// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: credit-based request issue, in-order response queue,
// redirect flush with stale-response dropping.
module riscv_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc_F,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic            imem_valid,
  input  logic [31:0]     instr_F,
  input  logic            pcsrc_E,
  input  logic [XLEN-1:0] pctarget_E,
  input  logic            stall_D,
  output logic            valid_D,
  output logic [31:0]     instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic [XLEN-1:0] pcplus4_D
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_q, pc_n;
  logic [CW-1:0]   count_q, count_n;
  logic [CW-1:0]   inflight_q, inflight_n;
  logic [CW-1:0]   drop_q, drop_n;
  logic [AW-1:0]   af_wr, af_wr_n, af_rd, af_rd_n;
  logic [AW-1:0]   q_wr, q_wr_n, q_rd, q_rd_n;

  logic [XLEN-1:0] af_mem  [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];

  logic [CW:0] used;
  logic        fire, rsp, enq, deq;

  assign pc_F      = pc_q;
  assign valid_D   = !reset && (count_q != '0);
  assign instr_D   = q_instr[q_rd];
  assign pc_D      = q_pc[q_rd];
  assign pcplus4_D = pc_D + XLEN'(4);

  // Credit check: every fired request is guaranteed a queue slot on return.
  always_comb begin
    used     = {1'b0, count_q} + {1'b0, inflight_q};
    imem_req = !reset && !pcsrc_E && (used < (CW + 1)'(DEPTH));
    fire     = imem_req && imem_ready;
    rsp      = imem_valid && !reset;
    enq      = rsp && (drop_q == '0) && !pcsrc_E;
    deq      = valid_D && !stall_D && !pcsrc_E;
  end

  always_comb begin
    pc_n       = pc_q;
    count_n    = count_q;
    inflight_n = inflight_q;
    drop_n     = drop_q;
    af_wr_n    = af_wr;
    af_rd_n    = af_rd;
    q_wr_n     = q_wr;
    q_rd_n     = q_rd;

    if (fire) begin
      pc_n    = pc_q + XLEN'(4);
      af_wr_n = af_wr + AW'(1);
    end
    if (rsp) af_rd_n = af_rd + AW'(1);

    case ({fire, rsp})
      2'b10:   inflight_n = inflight_q + CW'(1);
      2'b01:   inflight_n = inflight_q - CW'(1);
      default: ;
    endcase

    if (pcsrc_E) begin
      pc_n    = pctarget_E & ~XLEN'(3);
      count_n = '0;
      q_wr_n  = '0;
      q_rd_n  = '0;
      // drop is always a subset of inflight, so after a redirect every
      // request still outstanding is stale; this also covers back-to-back redirects.
      if (rsp && (inflight_q == '0)) drop_n = '0;
      else                           drop_n = inflight_q - CW'(rsp);
    end else begin
      if (rsp && (drop_q != '0)) drop_n = drop_q - CW'(1);
      if (enq) q_wr_n = q_wr + AW'(1);
      if (deq) q_rd_n = q_rd + AW'(1);
      case ({enq, deq})
        2'b10:   count_n = count_q + CW'(1);
        2'b01:   count_n = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      af_wr      <= '0;
      af_rd      <= '0;
      q_wr       <= '0;
      q_rd       <= '0;
    end else begin
      pc_q       <= pc_n;
      count_q    <= count_n;
      inflight_q <= inflight_n;
      drop_q     <= drop_n;
      af_wr      <= af_wr_n;
      af_rd      <= af_rd_n;
      q_wr       <= q_wr_n;
      q_rd       <= q_rd_n;
    end
  end

  // Storage arrays carry no reset; occupancy counters qualify their contents.
  always_ff @(posedge clk) begin
    if (fire) af_mem[af_wr] <= pc_q;
    if (enq) begin
      q_instr[q_wr] <= instr_F;
      q_pc[q_wr]    <= af_mem[af_rd];
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: in-order memory model with random
// latency/backpressure, expected decode stream derived from redirect/reset history.
module tb_riscv_fetch_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_F;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] instr_F = '0;
  logic        pcsrc_E = 1'b0;
  logic [31:0] pctarget_E = '0;
  logic        stall_D = 1'b0;
  logic        valid_D;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pcplus4_D;

  riscv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .pc_F(pc_F), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_valid(imem_valid), .instr_F(instr_F),
    .pcsrc_E(pcsrc_E), .pctarget_E(pctarget_E), .stall_D(stall_D),
    .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D), .pcplus4_D(pcplus4_D)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t        sb[$];
  mreq_t       mq[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          lat_min = 1, lat_max = 1, last_due = 0;
  int          n_accept = 0;
  logic [31:0] exp_fire = RST_PC, sb_next = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // After reset or redirect the decode stream restarts sequentially at the new address.
  task automatic restart(input logic [31:0] a);
    sb.delete();
    sb_next  = a;
    exp_fire = a;
  endtask

  // One clock of stimulus; returns #1 after the edge that ends the cycle.
  task automatic step(input bit rst, input bit redir, input logic [31:0] tgt,
                      input bit stall, input bit rdy);
    reset      = rst;
    pcsrc_E    = redir;
    pctarget_E = redir ? tgt : 32'($urandom);
    stall_D    = stall;
    imem_ready = rdy;
    if (rst) begin
      mq.delete();
      last_due   = cyc;
      imem_valid = 1'b0;
      instr_F    = 32'($urandom);
      restart(RST_PC);
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_valid = 1'b1;
        instr_F    = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_valid = 1'b0;
        instr_F    = 32'($urandom);
      end
      if (redir) restart(tgt & ~32'd3);
    end
    while (sb.size() < 16) begin
      exp_t e;
      e.pc    = sb_next;
      e.instr = mem_word(sb_next);
      sb.push_back(e);
      sb_next += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit stall, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, stall, rdy);
  endtask

  // Monitor: fire addresses, memory request capture, decode stream vs scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset || pcsrc_E) check("req_blocked", 32'(imem_req), 32'd0);
      if (reset) check("valid_in_reset", 32'(valid_D), 32'd0);
      if (imem_req && imem_ready) begin
        mreq_t m;
        int    lat;
        check("fire_addr", pc_F, exp_fire);
        exp_fire += 32'd4;
        lat   = int'($urandom_range(lat_max, lat_min));
        m.addr = pc_F;
        m.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = m.due;
        mq.push_back(m);
      end
      if (valid_D && !stall_D && !pcsrc_E && !reset) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pc_D", pc_D, e.pc);
          check("instr_D", instr_D, e.instr);
          check("pcplus4_D", pcplus4_D, e.pc + 32'd4);
          n_accept++;
        end
      end
    end
  end

  initial begin
    bit found;

    // Reset and streaming across the address wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check("reset_pc", pc_F, RST_PC);
    check("reset_valid", 32'(valid_D), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("stream_v0", 32'(valid_D), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("stream_v1", 32'(valid_D), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("stream_cont", 32'(valid_D), 32'd1);
    end

    // Backpressure after a redirect to 0, plus redirect-to-valid latency.
    idle(8, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    check("redir_v_r1", 32'(valid_D), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("redir_v_r2", 32'(valid_D), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("redir_v_r3", 32'(valid_D), 32'd1);
    idle(8, 1'b1, 1'b1);
    check("bp_pc_hold", pc_F, 32'h10);
    check("bp_req_low", 32'(imem_req), 32'd0);
    idle(12, 1'b0, 1'b1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    idle(8, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b1);
    check("inflight_pending", 32'(mq.size()), 32'd2);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    check("redir_pc", pc_F, 32'h100);
    idle(16, 1'b0, 1'b1);

    // Redirect in the same cycle as a response, unaligned target.
    lat_min = 2; lat_max = 2;
    idle(8, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    check("coincide_found", 32'(found), 32'd1);
    step(1'b0, 1'b1, 32'h203, 1'b0, 1'b1);
    check("coincide_pc", pc_F, 32'h200);
    idle(16, 1'b0, 1'b1);

    // Mid-operation reset with a full queue and requests in flight.
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check("midrst_pc", pc_F, RST_PC);
    check("midrst_valid", 32'(valid_D), 32'd0);
    idle(12, 1'b0, 1'b1);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(999);
      if (r < 3) begin
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      end else if (r < 33) begin
        step(1'b0, 1'b1, 32'($urandom_range(32'hFFF)), $urandom_range(99) < 30,
             $urandom_range(99) < 75);
      end else begin
        step(1'b0, 1'b0, 32'h0, $urandom_range(99) < 30, $urandom_range(99) < 75);
      end
    end
    idle(20, 1'b0, 1'b1);
    check("progress", 32'(n_accept > 500), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
